// File: rtl/ifq_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifq_fetch_ctrl_if
// Bundle of the fetch sequencer's handshakes: redirect input, instruction
// memory request/response channel, IFQ write/flush port and status outputs.
//   master : the fetch controller (drives mem_req/mem_addr, fifo_*, start_word, busy)
//   slave  : the environment (core redirect source, memory, IFQ)
// ---------------------------------------------------------------------------
interface ifq_fetch_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
);
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [LINE_WIDTH-1:0] mem_rdata;
   logic                  fifo_full;
   logic                  fifo_wen;
   logic [LINE_WIDTH-1:0] fifo_wdata;
   logic                  fifo_flush;
   logic [1:0]            start_word;
   logic                  busy;

   modport master (
      input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, fifo_full,
      output mem_req, mem_addr, fifo_wen, fifo_wdata, fifo_flush, start_word, busy
   );

   modport slave (
      output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, fifo_full,
      input  mem_req, mem_addr, fifo_wen, fifo_wdata, fifo_flush, start_word, busy
   );
endinterface

// File: rtl/ifq_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifq_fetch_ctrl
// Fetch sequencer for the 4-deep x 128-bit instruction fetch queue.
// Walks a line-aligned fetch PC, issues one line read at a time to
// instruction memory, pushes each returned line into the IFQ (holding it
// locally while the IFQ is full) and restarts cleanly on a redirect.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : ifq_fetch_ctrl_if.master
//          redirect/redirect_pc  restart request and target byte address
//          mem_req/mem_addr      line read request (addr bits[3:0]=0)
//          mem_gnt               memory accepts the request this cycle
//          mem_rvalid/mem_rdata  one response per granted request
//          fifo_full             IFQ full flag
//          fifo_wen/fifo_wdata   IFQ write port
//          fifo_flush            IFQ flush, equal to redirect
//          start_word            word offset of the redirect target in the first line
//          busy                  a request is outstanding (REQ/WAIT/DROP)
// ---------------------------------------------------------------------------
module ifq_fetch_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    LINE_WIDTH = 128,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
   input logic               clk,
   input logic               rst,
   ifq_fetch_ctrl_if.master  bus
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;
   localparam logic [2:0] ST_DROP = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(16);

   logic [2:0]            state_r;
   logic [2:0]            state_nxt_s;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] pc_nxt_s;
   logic [LINE_WIDTH-1:0] buf_r;
   logic [LINE_WIDTH-1:0] buf_nxt_s;
   logic [1:0]            start_word_r;
   logic [1:0]            start_word_nxt_s;
   logic                  wen_s;
   logic                  unused_pc_bits_s;

   // Byte offset within a word never affects the fetch; only [3:2] is kept.
   assign unused_pc_bits_s = ^bus.redirect_pc[1:0];

   // Next-state, PC, line buffer and IFQ write decision; redirect wins over everything.
   always_comb begin
      state_nxt_s      = state_r;
      pc_nxt_s         = pc_r;
      buf_nxt_s        = buf_r;
      start_word_nxt_s = start_word_r;
      wen_s            = 1'b0;
      if (bus.redirect) begin
         pc_nxt_s         = {bus.redirect_pc[ADDR_WIDTH-1:4], 4'b0000};
         start_word_nxt_s = bus.redirect_pc[3:2];
         // DROP only when a response is still owed after this cycle.
         case (state_r)
            ST_REQ:           state_nxt_s = bus.mem_gnt ? ST_DROP : ST_REQ;
            ST_WAIT, ST_DROP: state_nxt_s = bus.mem_rvalid ? ST_REQ : ST_DROP;
            default:          state_nxt_s = ST_REQ;
         endcase
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s = ST_REQ;
            end
            ST_REQ: begin
               if (bus.mem_gnt) begin
                  state_nxt_s = ST_WAIT;
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (bus.mem_rvalid && !bus.fifo_full) begin
                  wen_s            = 1'b1;
                  pc_nxt_s         = pc_r + LINE_BYTES;
                  start_word_nxt_s = 2'd0;
                  state_nxt_s      = ST_REQ;
               end else if (bus.mem_rvalid) begin
                  buf_nxt_s   = bus.mem_rdata;
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
            ST_HOLD: begin
               if (!bus.fifo_full) begin
                  wen_s            = 1'b1;
                  pc_nxt_s         = pc_r + LINE_BYTES;
                  start_word_nxt_s = 2'd0;
                  state_nxt_s      = ST_REQ;
               end else begin
                  state_nxt_s = ST_HOLD;
               end
            end
            ST_DROP: begin
               if (bus.mem_rvalid) begin
                  state_nxt_s = ST_REQ;
               end else begin
                  state_nxt_s = ST_DROP;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, fetch PC, line buffer and start word registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         pc_r         <= RESET_PC;
         buf_r        <= {LINE_WIDTH{1'b0}};
         start_word_r <= 2'd0;
      end else begin
         state_r      <= state_nxt_s;
         pc_r         <= pc_nxt_s;
         buf_r        <= buf_nxt_s;
         start_word_r <= start_word_nxt_s;
      end
   end

   assign bus.mem_req    = (state_r == ST_REQ);
   assign bus.mem_addr   = pc_r;
   assign bus.fifo_wen   = wen_s;
   // WAIT forwards the memory line directly; HOLD replays the captured one.
   assign bus.fifo_wdata = (state_r == ST_HOLD) ? buf_r : bus.mem_rdata;
   assign bus.fifo_flush = bus.redirect;
   assign bus.start_word = start_word_r;
   assign bus.busy       = (state_r == ST_REQ) || (state_r == ST_WAIT) || (state_r == ST_DROP);

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
module tb_ifq_fetch_ctrl;

   logic clk;
   logic rst;

   ifq_fetch_ctrl_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) ifc ();

   ifq_fetch_ctrl #(
      .ADDR_WIDTH(32),
      .LINE_WIDTH(128),
      .RESET_PC(32'h0040_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Line content returned by the memory model for a given address
   function automatic logic [127:0] line_of(input logic [31:0] a);
      return {a, a ^ 32'h1111_1111, a ^ 32'h2222_2222, a ^ 32'h3333_3333};
   endfunction

   // ---------------- memory responder: always grants, responds lat cycles later
   int          cyc = 0;
   int          lat = 2;
   int          due = 0;
   bit          pend = 1'b0;
   logic [127:0] pdata = 128'd0;

   always @(posedge clk) begin
      #2;
      cyc++;
      ifc.mem_rvalid = 1'b0;
      ifc.mem_gnt    = 1'b0;
      ifc.mem_rdata  = {4{32'hDEAD_BEEF}};
      if (pend && cyc == due) begin
         ifc.mem_rvalid = 1'b1;
         ifc.mem_rdata  = pdata;
         pend           = 1'b0;
      end
      if (ifc.mem_req) begin
         ifc.mem_gnt = 1'b1;
         pend        = 1'b1;
         due         = cyc + lat;
         pdata       = line_of(ifc.mem_addr);
      end
   end

   // ---------------- transaction-level reference model + per-cycle compare
   bit           m_idle    = 1'b1;
   bit           m_owed    = 1'b0;
   bit           m_discard = 1'b0;
   bit           m_held    = 1'b0;
   logic [127:0] m_hdata   = 128'd0;
   logic [31:0]  m_addr    = 32'h0040_0000;
   logic [1:0]   m_sw      = 2'd0;
   bit           e_req, e_wen, rv, granted;
   logic [127:0] e_wd;
   int           wen_cnt = 0;
   logic [31:0]  glog[$];
   logic [127:0] wlog[$];

   always @(negedge clk) begin
      if (rst) begin
         check("rst_mem_req", ifc.mem_req, 128'd0);
         check("rst_fifo_wen", ifc.fifo_wen, 128'd0);
         check("rst_busy", ifc.busy, 128'd0);
         check("rst_start_word", ifc.start_word, 128'd0);
         m_idle = 1'b1; m_owed = 1'b0; m_discard = 1'b0; m_held = 1'b0;
         m_addr = 32'h0040_0000; m_sw = 2'd0;
      end else begin
         e_req = !m_idle && !m_owed && !m_held;
         rv    = ifc.mem_rvalid && m_owed;
         e_wen = 1'b0;
         e_wd  = 128'd0;
         if (!ifc.redirect) begin
            if (m_held && !ifc.fifo_full) begin
               e_wen = 1'b1; e_wd = m_hdata;
            end else if (rv && !m_discard && !ifc.fifo_full) begin
               e_wen = 1'b1; e_wd = ifc.mem_rdata;
            end
         end
         check("mem_req", ifc.mem_req, e_req);
         check("busy", ifc.busy, e_req || m_owed);
         check("fifo_flush", ifc.fifo_flush, ifc.redirect);
         check("fifo_wen", ifc.fifo_wen, e_wen);
         check("start_word", ifc.start_word, m_sw);
         if (e_req) check("mem_addr", ifc.mem_addr, m_addr);
         if (e_wen) check("fifo_wdata", ifc.fifo_wdata, e_wd);
         if (ifc.fifo_wen) begin
            wen_cnt++;
            wlog.push_back(ifc.fifo_wdata);
         end
         if (ifc.mem_req && ifc.mem_gnt) glog.push_back(ifc.mem_addr);

         granted = e_req && ifc.mem_gnt;
         m_idle  = 1'b0;
         if (ifc.redirect) begin
            m_addr    = {ifc.redirect_pc[31:4], 4'b0000};
            m_sw      = ifc.redirect_pc[3:2];
            m_held    = 1'b0;
            m_owed    = (m_owed && !rv) || granted;
            m_discard = m_owed;
         end else begin
            if (rv) begin
               m_owed = 1'b0;
               if (m_discard) m_discard = 1'b0;
               else if (ifc.fifo_full) begin
                  m_held = 1'b1; m_hdata = ifc.mem_rdata;
               end
            end else if (m_held && e_wen) begin
               m_held = 1'b0;
            end
            if (granted) m_owed = 1'b1;
            if (e_wen) begin
               m_addr = m_addr + 32'd16;
               m_sw   = 2'd0;
            end
         end
      end
   end

   // ---------------- bounded waits
   task automatic wait_writes(input int n, input int budget, input string nm);
      int k = 0;
      while (wen_cnt < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(nm, wen_cnt, n);
   endtask

   task automatic wait_grants(input int n, input int budget, input string nm);
      int k = 0;
      while (glog.size() < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(nm, glog.size(), n);
   endtask

   function automatic logic [31:0] g_at(input int i);
      return (i < glog.size()) ? glog[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [127:0] w_at(input int i);
      return (i < wlog.size()) ? wlog[i] : {128{1'bx}};
   endfunction

   int k5;

   initial begin
      rst             = 1'b1;
      ifc.redirect    = 1'b0;
      ifc.redirect_pc = 32'd0;
      ifc.fifo_full   = 1'b0;
      ifc.mem_gnt     = 1'b0;
      ifc.mem_rvalid  = 1'b0;
      ifc.mem_rdata   = 128'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_mem_addr", ifc.mem_addr, 32'h0040_0000);
      check("reset_fifo_flush", ifc.fifo_flush, 1'b0);
      rst = 1'b0;

      // 1: sequential fetch of three lines
      wait_writes(3, 40, "t1_writes");
      check("t1_addr0", g_at(0), 32'h0040_0000);
      check("t1_addr1", g_at(1), 32'h0040_0010);
      check("t1_addr2", g_at(2), 32'h0040_0020);
      check("t1_data0", w_at(0), {32'h0040_0000, 32'h1151_1111, 32'h2262_2222, 32'h3373_3333});

      // 2: IFQ full when line 0x0040_0030 returns
      ifc.fifo_full = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      check("t2_no_write", wen_cnt, 3);
      check("t2_no_new_req", glog.size(), 4);
      check("t2_hold_req", ifc.mem_req, 1'b0);
      ifc.fifo_full = 1'b0;
      wait_writes(4, 10, "t2_writes");
      lat = 3;
      check("t2_held_data", w_at(3), {32'h0040_0030, 32'h1151_1121, 32'h2262_2212, 32'h3373_3303});
      wait_grants(5, 10, "t2_grants");
      check("t2_next_addr", g_at(4), 32'h0040_0040);

      // 3: redirect while waiting, late response dropped
      ifc.redirect    = 1'b1;
      ifc.redirect_pc = 32'h0000_1238;
      #1;
      check("t3_flush", ifc.fifo_flush, 1'b1);
      @(posedge clk); #1;
      ifc.redirect = 1'b0;
      lat = 2;
      check("t3_start_word", ifc.start_word, 2'd2);
      check("t3_drop_busy", ifc.busy, 1'b1);
      wait_writes(5, 20, "t3_writes");
      check("t3_addr", g_at(5), 32'h0000_1230);
      check("t3_data", w_at(4), {32'h0000_1230, 32'h1111_0321, 32'h2222_3012, 32'h3333_2103});
      check("t3_start_word_clr", ifc.start_word, 2'd0);

      // 4: redirect in the same cycle as a grant
      ifc.redirect    = 1'b1;
      ifc.redirect_pc = 32'h0000_2004;
      @(posedge clk); #1;
      ifc.redirect = 1'b0;
      check("t4_start_word", ifc.start_word, 2'd1);
      wait_writes(6, 20, "t4_writes");
      check("t4_granted", g_at(6), 32'h0000_1240);
      check("t4_addr", g_at(7), 32'h0000_2000);
      check("t4_data", w_at(5), {32'h0000_2000, 32'h1111_3111, 32'h2222_0222, 32'h3333_1333});

      // 5: PC wraps at the top of the address space
      ifc.redirect    = 1'b1;
      ifc.redirect_pc = 32'hFFFF_FFF0;
      @(posedge clk); #1;
      ifc.redirect = 1'b0;
      k5 = glog.size();
      wait_writes(8, 30, "t5_writes");
      check("t5_addr_top", g_at(k5), 32'hFFFF_FFF0);
      check("t5_addr_wrap", g_at(k5 + 1), 32'h0000_0000);

      // 6: reset while waiting; stale response arrives after release
      lat = 3;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("t6_rst_req", ifc.mem_req, 1'b0);
      check("t6_rst_busy", ifc.busy, 1'b0);
      check("t6_rst_wen", ifc.fifo_wen, 1'b0);
      check("t6_rst_addr", ifc.mem_addr, 32'h0040_0000);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_writes(9, 30, "t6_writes");
      check("t6_restart_addr", g_at(glog.size() - 1), 32'h0040_0000);
      check("t6_data", w_at(8), {32'h0040_0000, 32'h1151_1111, 32'h2262_2222, 32'h3373_3333});

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
